// File: rtl/cache_axi_arbiter_if.sv
// Cache-to-bridge arbiter bus: icache/dcache request and return channels,
// flush, and the AXI bridge side. slave = arbiter, master = caches + bridge.
interface cache_axi_arbiter_if #(
    parameter int LEN_W  = 8,
    parameter int ADDR_W = 32
);
    logic              flush;
    // icache refill channel
    logic              i_ren;
    logic [ADDR_W-1:0] i_raddr;
    logic [LEN_W-1:0]  i_rlen;
    logic              i_ack;
    logic [ADDR_W-1:0] i_rdata;
    logic              i_rvalid;
    logic              i_rlast;
    // dcache read channel
    logic              d_ren;
    logic [ADDR_W-1:0] d_raddr;
    logic [LEN_W-1:0]  d_rlen;
    logic [3:0]        d_rsel;
    logic              d_ack;
    logic [ADDR_W-1:0] d_rdata;
    logic              d_rvalid;
    logic              d_rlast;
    // dcache write channel
    logic              d_wen;
    logic [ADDR_W-1:0] d_waddr;
    logic [LEN_W-1:0]  d_wlen;
    logic [3:0]        d_wsel;
    logic [ADDR_W-1:0] d_wdata;
    logic              d_wvalid;
    logic              d_wack;
    logic              d_wready;
    logic              d_wdone;
    // bridge side
    logic              cache_ce;
    logic              cache_ren;
    logic              cache_wen;
    logic [ADDR_W-1:0] cache_raddr;
    logic [ADDR_W-1:0] cache_waddr;
    logic [ADDR_W-1:0] cache_wdata;
    logic [3:0]        cache_rsel;
    logic [3:0]        cache_wsel;
    logic [LEN_W-1:0]  cacher_burst_length;
    logic [LEN_W-1:0]  cachew_burst_length;
    logic              cache_wvalid;
    logic              cache_wlast;
    logic [ADDR_W-1:0] rdata_i;
    logic              rdata_valid_i;
    logic              wdata_resp_i;
    logic              stallreq;

    modport slave (
        input  flush,
        input  i_ren, i_raddr, i_rlen,
        output i_ack, i_rdata, i_rvalid, i_rlast,
        input  d_ren, d_raddr, d_rlen, d_rsel,
        output d_ack, d_rdata, d_rvalid, d_rlast,
        input  d_wen, d_waddr, d_wlen, d_wsel, d_wdata, d_wvalid,
        output d_wack, d_wready, d_wdone,
        output cache_ce, cache_ren, cache_wen,
        output cache_raddr, cache_waddr, cache_wdata,
        output cache_rsel, cache_wsel,
        output cacher_burst_length, cachew_burst_length,
        output cache_wvalid, cache_wlast,
        input  rdata_i, rdata_valid_i, wdata_resp_i,
        output stallreq
    );

    modport master (
        output flush,
        output i_ren, i_raddr, i_rlen,
        input  i_ack, i_rdata, i_rvalid, i_rlast,
        output d_ren, d_raddr, d_rlen, d_rsel,
        input  d_ack, d_rdata, d_rvalid, d_rlast,
        output d_wen, d_waddr, d_wlen, d_wsel, d_wdata, d_wvalid,
        input  d_wack, d_wready, d_wdone,
        input  cache_ce, cache_ren, cache_wen,
        input  cache_raddr, cache_waddr, cache_wdata,
        input  cache_rsel, cache_wsel,
        input  cacher_burst_length, cachew_burst_length,
        input  cache_wvalid, cache_wlast,
        output rdata_i, rdata_valid_i, wdata_resp_i,
        input  stallreq
    );
endinterface

// File: rtl/cache_axi_arbiter.sv
// Arbitrates icache/dcache reads (round-robin) and dcache writes onto one
// AXI bridge. Ports: clk, rst (sync, active-high), bus (slave modport).
module cache_axi_arbiter #(
    parameter int LEN_W  = 8,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    cache_axi_arbiter_if.slave bus
);
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_DATA, R_DONE} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_DATA} w_state_t;

    r_state_t          r_state;
    w_state_t          w_state;
    logic              r_is_d;
    logic              rr_d_first;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;
    logic [LEN_W-1:0]  w_len;
    logic [LEN_W-1:0]  w_cnt;
    logic [3:0]        r_sel;
    logic [3:0]        w_sel;

    logic d_ok;
    logic grant_d;
    logic grant_i;
    logic r_beat;
    logic r_end;
    logic w_beat;
    logic w_end;
    logic w_take;
    logic r_req;
    logic w_req;
    logic w_data;

    // A read of the line currently being written back must wait for it.
    assign d_ok = bus.d_ren &&
                  !(w_state != W_IDLE && bus.d_raddr == w_addr);

    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (r_state == R_IDLE && !bus.flush) begin
            if (d_ok && bus.i_ren) begin
                grant_d = rr_d_first;
                grant_i = !rr_d_first;
            end else begin
                grant_d = d_ok;
                grant_i = bus.i_ren;
            end
        end
    end

    assign r_beat = r_state == R_DATA && bus.rdata_valid_i && !bus.flush;
    assign r_end  = r_beat && r_cnt == r_len;
    assign w_beat = w_state == W_DATA && bus.wdata_resp_i && !bus.flush;
    assign w_end  = w_beat && w_cnt == w_len;
    assign w_take = w_state == W_IDLE && bus.d_wen && !bus.flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= R_IDLE;
            r_is_d     <= 1'b0;
            rr_d_first <= 1'b1;
            r_addr     <= '0;
            r_len      <= '0;
            r_sel      <= '0;
            r_cnt      <= '0;
        end else if (bus.flush) begin
            r_state <= R_IDLE;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    if (grant_d || grant_i) begin
                        r_state    <= R_REQ;
                        r_is_d     <= grant_d;
                        rr_d_first <= grant_i;
                        r_addr     <= grant_d ? bus.d_raddr : bus.i_raddr;
                        r_len      <= grant_d ? bus.d_rlen : bus.i_rlen;
                        r_sel      <= grant_d ? bus.d_rsel : 4'hF;
                        r_cnt      <= '0;
                    end
                end
                R_REQ: r_state <= R_DATA;
                R_DATA: begin
                    if (r_end) begin
                        r_state <= R_DONE;
                        r_cnt   <= '0;
                    end else if (r_beat) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                R_DONE: r_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            w_addr  <= '0;
            w_len   <= '0;
            w_sel   <= '0;
            w_cnt   <= '0;
        end else if (bus.flush) begin
            w_state <= W_IDLE;
            w_cnt   <= '0;
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    if (w_take) begin
                        w_state <= W_REQ;
                        w_addr  <= bus.d_waddr;
                        w_len   <= bus.d_wlen;
                        w_sel   <= bus.d_wsel;
                        w_cnt   <= '0;
                    end
                end
                W_REQ: w_state <= W_DATA;
                W_DATA: begin
                    if (w_end) begin
                        w_state <= W_IDLE;
                        w_cnt   <= '0;
                    end else if (w_beat) begin
                        w_cnt <= w_cnt + 1'b1;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    assign r_req  = r_state == R_REQ;
    assign w_req  = w_state == W_REQ;
    assign w_data = w_state == W_DATA;

    assign bus.i_ack    = grant_i;
    assign bus.d_ack    = grant_d;
    assign bus.i_rvalid = r_beat && !r_is_d;
    assign bus.d_rvalid = r_beat && r_is_d;
    assign bus.i_rlast  = bus.i_rvalid && r_cnt == r_len;
    assign bus.d_rlast  = bus.d_rvalid && r_cnt == r_len;
    assign bus.i_rdata  = bus.i_rvalid ? bus.rdata_i : '0;
    assign bus.d_rdata  = bus.d_rvalid ? bus.rdata_i : '0;

    assign bus.d_wack   = w_take;
    assign bus.d_wready = w_beat;
    assign bus.d_wdone  = w_end;

    assign bus.cache_ce  = r_req || w_req;
    assign bus.cache_ren = r_req;
    assign bus.cache_wen = w_req;
    assign bus.cache_raddr = r_req ? r_addr : '0;
    assign bus.cache_rsel  = r_req ? r_sel : 4'h0;
    assign bus.cacher_burst_length = r_req ? r_len : '0;
    assign bus.cache_waddr = w_req ? w_addr : '0;
    assign bus.cache_wsel  = w_req ? w_sel : 4'h0;
    assign bus.cachew_burst_length = w_req ? w_len : '0;

    assign bus.cache_wdata  = w_data ? bus.d_wdata : '0;
    assign bus.cache_wvalid = w_data && bus.d_wvalid;
    assign bus.cache_wlast  = w_data && w_cnt == w_len;

    assign bus.stallreq = r_state != R_IDLE || w_state != W_IDLE ||
                          bus.i_ren || bus.d_ren || bus.d_wen;
endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Scoreboard bench for cache_axi_arbiter: directed stimulus pushes expected
// events into queues, a negedge monitor pops and compares them.
module tb_cache_axi_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   wready_cnt = 0;

    localparam int ID_IACK  = 0;
    localparam int ID_DACK  = 1;
    localparam int ID_REN   = 2;
    localparam int ID_WACK  = 3;
    localparam int ID_WEN   = 4;
    localparam int ID_WDONE = 5;

    int          ctrl_q[$];
    logic [32:0] ir_q[$];
    logic [32:0] dr_q[$];
    logic [32:0] wr_q[$];
    logic [43:0] rq_q[$];
    logic [43:0] wq_q[$];

    cache_axi_arbiter_if #(.LEN_W(8), .ADDR_W(32)) bus ();

    cache_axi_arbiter #(.LEN_W(8), .ADDR_W(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic unexp(input string nm);
        checks++;
        failures++;
        $display("FAIL %s actual=pulse required=none", nm);
    endtask

    task automatic pop_ctrl(input int ev, input string nm);
        if (ctrl_q.size() == 0) unexp(nm);
        else chk(nm, 64'(ev), 64'(ctrl_q.pop_front()));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.i_ack)   pop_ctrl(ID_IACK, "i_ack");
            if (bus.d_ack)   pop_ctrl(ID_DACK, "d_ack");
            if (bus.d_wack)  pop_ctrl(ID_WACK, "d_wack");
            if (bus.d_wdone) pop_ctrl(ID_WDONE, "d_wdone");
            if (bus.i_rvalid) begin
                if (ir_q.size() == 0) unexp("i_rvalid");
                else chk("i_beat", 64'({bus.i_rlast, bus.i_rdata}),
                         64'(ir_q.pop_front()));
            end
            if (bus.d_rvalid) begin
                if (dr_q.size() == 0) unexp("d_rvalid");
                else chk("d_beat", 64'({bus.d_rlast, bus.d_rdata}),
                         64'(dr_q.pop_front()));
            end
            if (bus.d_wready) begin
                wready_cnt++;
                if (wr_q.size() == 0) unexp("d_wready");
                else chk("w_beat", 64'({bus.cache_wvalid, bus.cache_wlast,
                                        bus.cache_wdata}),
                         64'({1'b1, wr_q.pop_front()}));
            end
            if (bus.cache_ren) begin
                if (rq_q.size() == 0) unexp("cache_ren");
                else chk("rd_req", 64'({bus.cache_ce, bus.cache_raddr,
                                        bus.cacher_burst_length,
                                        bus.cache_rsel}),
                         64'({1'b1, rq_q.pop_front()}));
            end
            if (bus.cache_wen) begin
                if (wq_q.size() == 0) unexp("cache_wen");
                else chk("wr_req", 64'({bus.cache_ce, bus.cache_waddr,
                                        bus.cachew_burst_length,
                                        bus.cache_wsel}),
                         64'({1'b1, wq_q.pop_front()}));
            end
        end
    end

    function automatic logic sig(input int id);
        case (id)
            ID_IACK:  return bus.i_ack;
            ID_DACK:  return bus.d_ack;
            ID_REN:   return bus.cache_ren;
            ID_WACK:  return bus.d_wack;
            ID_WEN:   return bus.cache_wen;
            ID_WDONE: return bus.d_wdone;
            default:  return 1'b0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_for(input int id, input string nm, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sig(id) && n < 200);
        if (!sig(id)) begin
            checks++;
            failures++;
            $display("FAIL timeout_%s actual=absent required=pulse", nm);
        end
    endtask

    task automatic exp_read(input bit is_d, input logic [31:0] addr,
                            input logic [7:0] len, input logic [3:0] sel,
                            input logic [31:0] base, input int nbeats);
        rq_q.push_back({addr, len, is_d ? sel : 4'hF});
        for (int k = 0; k < nbeats; k++) begin
            if (is_d) dr_q.push_back({k == int'(len), base + 32'(k)});
            else      ir_q.push_back({k == int'(len), base + 32'(k)});
        end
    endtask

    task automatic bridge(input int len, input logic [31:0] base);
        int n;
        wait_for(ID_REN, "cache_ren", n);
        for (int k = 0; k <= len; k++) begin
            tick();
            bus.rdata_valid_i = 1'b1;
            bus.rdata_i = base + 32'(k);
        end
        tick();
        bus.rdata_valid_i = 1'b0;
        bus.rdata_i = '0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                            input logic [31:0] base, input bit gap,
                            input bit with_read);
        int n;
        ctrl_q.push_back(ID_WACK);
        ctrl_q.push_back(ID_WDONE);
        wq_q.push_back({addr, len, 4'hF});
        for (int k = 0; k <= int'(len); k++)
            wr_q.push_back({k == int'(len), base + 32'(k)});
        bus.d_wen = 1'b1;
        bus.d_waddr = addr;
        bus.d_wlen = len;
        bus.d_wsel = 4'hF;
        wait_for(ID_WACK, "d_wack", n);
        tick();
        bus.d_wen = 1'b0;
        wait_for(ID_WEN, "cache_wen", n);
        tick();
        if (with_read) begin
            ctrl_q.push_back(ID_DACK);
            exp_read(1'b1, addr, 8'd0, 4'b0001, 32'hE000_0000, 1);
            bus.d_ren = 1'b1;
            bus.d_raddr = addr;
            bus.d_rlen = 8'd0;
            bus.d_rsel = 4'b0001;
            tick();
            tick();
        end
        for (int k = 0; k <= int'(len); k++) begin
            bus.d_wvalid = 1'b1;
            bus.d_wdata = base + 32'(k);
            bus.wdata_resp_i = 1'b1;
            tick();
            if (gap && k != int'(len)) begin
                bus.wdata_resp_i = 1'b0;
                tick();
            end
        end
        bus.wdata_resp_i = 1'b0;
        bus.d_wvalid = 1'b0;
        bus.d_wdata = '0;
        if (with_read) begin
            wait_for(ID_DACK, "d_ack", n);
            chk("raw_grant_delay", 64'(n), 64'd1);
            tick();
            bus.d_ren = 1'b0;
            bridge(0, 32'hE000_0000);
        end
    endtask

    initial begin
        int n;
        int w0;
        bus.flush = 0;
        bus.i_ren = 0; bus.i_raddr = '0; bus.i_rlen = '0;
        bus.d_ren = 0; bus.d_raddr = '0; bus.d_rlen = '0; bus.d_rsel = '0;
        bus.d_wen = 0; bus.d_waddr = '0; bus.d_wlen = '0; bus.d_wsel = '0;
        bus.d_wdata = '0; bus.d_wvalid = 0;
        bus.rdata_i = '0; bus.rdata_valid_i = 0; bus.wdata_resp_i = 0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_read_out", 64'(|{bus.i_ack, bus.d_ack, bus.i_rvalid,
            bus.i_rlast, bus.d_rvalid, bus.d_rlast, bus.i_rdata,
            bus.d_rdata}), 64'd0);
        chk("rst_write_out", 64'(|{bus.d_wack, bus.d_wready,
            bus.d_wdone}), 64'd0);
        chk("rst_cache_out", 64'(|{bus.cache_ce, bus.cache_ren,
            bus.cache_wen, bus.cache_raddr, bus.cache_waddr,
            bus.cache_wdata, bus.cache_rsel, bus.cache_wsel,
            bus.cacher_burst_length, bus.cachew_burst_length,
            bus.cache_wvalid, bus.cache_wlast}), 64'd0);
        chk("rst_stallreq", 64'(bus.stallreq), 64'd0);

        // single icache burst of 4
        tick();
        ctrl_q.push_back(ID_IACK);
        exp_read(1'b0, 32'h0000_1000, 8'd3, 4'h0, 32'hA000_0000, 4);
        bus.i_ren = 1; bus.i_raddr = 32'h0000_1000; bus.i_rlen = 8'd3;
        wait_for(ID_IACK, "i_ack", n);
        tick();
        bus.i_ren = 0;
        chk("stall_busy", 64'(bus.stallreq), 64'd1);
        bridge(3, 32'hA000_0000);
        repeat (2) tick();

        // fresh reset, then both request: dcache wins first
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        ctrl_q.push_back(ID_DACK);
        ctrl_q.push_back(ID_IACK);
        exp_read(1'b1, 32'h0000_2000, 8'd1, 4'b0011, 32'hB000_0000, 2);
        exp_read(1'b0, 32'h0000_3000, 8'd0, 4'h0, 32'hC000_0000, 1);
        bus.i_ren = 1; bus.i_raddr = 32'h0000_3000; bus.i_rlen = 8'd0;
        bus.d_ren = 1; bus.d_raddr = 32'h0000_2000; bus.d_rlen = 8'd1;
        bus.d_rsel = 4'b0011;
        wait_for(ID_DACK, "d_ack", n);
        tick();
        bus.d_ren = 0;
        bridge(1, 32'hB000_0000);
        wait_for(ID_IACK, "i_ack", n);
        chk("rdone_gap", 64'(n), 64'd2);
        tick();
        bus.i_ren = 0;
        bridge(0, 32'hC000_0000);
        repeat (2) tick();

        // lone dcache read, then both: icache now has priority
        ctrl_q.push_back(ID_DACK);
        exp_read(1'b1, 32'h0000_2100, 8'd0, 4'b1100, 32'hD000_0000, 1);
        bus.d_ren = 1; bus.d_raddr = 32'h0000_2100; bus.d_rlen = 8'd0;
        bus.d_rsel = 4'b1100;
        wait_for(ID_DACK, "d_ack", n);
        tick();
        bus.d_ren = 0;
        bridge(0, 32'hD000_0000);
        repeat (2) tick();
        ctrl_q.push_back(ID_IACK);
        ctrl_q.push_back(ID_DACK);
        exp_read(1'b0, 32'h0000_3100, 8'd0, 4'h0, 32'hC100_0000, 1);
        exp_read(1'b1, 32'h0000_2200, 8'd0, 4'b1111, 32'hD100_0000, 1);
        bus.i_ren = 1; bus.i_raddr = 32'h0000_3100; bus.i_rlen = 8'd0;
        bus.d_ren = 1; bus.d_raddr = 32'h0000_2200; bus.d_rlen = 8'd0;
        bus.d_rsel = 4'b1111;
        wait_for(ID_IACK, "i_ack", n);
        tick();
        bus.i_ren = 0;
        bridge(0, 32'hC100_0000);
        wait_for(ID_DACK, "d_ack", n);
        tick();
        bus.d_ren = 0;
        bridge(0, 32'hD100_0000);
        repeat (2) tick();

        // read of the address being written is held off until d_wdone
        do_write(32'h1C00_0100, 8'd1, 32'h1111_0000, 1'b0, 1'b1);
        repeat (2) tick();

        // 8-beat write with the bridge accepting every other cycle
        w0 = wready_cnt;
        do_write(32'h0000_4000, 8'd7, 32'h5500_0000, 1'b1, 1'b0);
        repeat (2) tick();
        chk("wready_count", 64'(wready_cnt - w0), 64'd8);

        // flush mid-burst after two of four beats
        ctrl_q.push_back(ID_IACK);
        exp_read(1'b0, 32'h0000_5000, 8'd3, 4'h0, 32'hF000_0000, 2);
        bus.i_ren = 1; bus.i_raddr = 32'h0000_5000; bus.i_rlen = 8'd3;
        wait_for(ID_IACK, "i_ack", n);
        tick();
        bus.i_ren = 0;
        wait_for(ID_REN, "cache_ren", n);
        for (int k = 0; k < 3; k++) begin
            tick();
            bus.rdata_valid_i = 1'b1;
            bus.rdata_i = 32'hF000_0000 + 32'(k);
            if (k == 2) bus.flush = 1'b1;
        end
        tick();
        bus.flush = 1'b0;
        bus.rdata_valid_i = 1'b0;
        bus.rdata_i = '0;
        ctrl_q.push_back(ID_IACK);
        exp_read(1'b0, 32'h0000_6000, 8'd0, 4'h0, 32'h7700_0000, 1);
        bus.i_ren = 1; bus.i_raddr = 32'h0000_6000; bus.i_rlen = 8'd0;
        wait_for(ID_IACK, "i_ack", n);
        chk("post_flush_ack", 64'(n), 64'd1);
        tick();
        bus.i_ren = 0;
        bridge(0, 32'h7700_0000);
        repeat (3) tick();

        chk("ctrl_q_left", 64'(ctrl_q.size()), 64'd0);
        chk("ir_q_left", 64'(ir_q.size()), 64'd0);
        chk("dr_q_left", 64'(dr_q.size()), 64'd0);
        chk("wr_q_left", 64'(wr_q.size()), 64'd0);
        chk("rq_q_left", 64'(rq_q.size()), 64'd0);
        chk("wq_q_left", 64'(wq_q.size()), 64'd0);
        chk("idle_stallreq", 64'(bus.stallreq), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
